// File: rtl/data_mem_responder_if.sv
// LSU <-> data RAM request/response bus.
//
// Handshake: a request (req, we, addr, wmask, wdata) is taken on the rising
// edge where req & ready are both high; the master holds its request fields
// stable until that edge. Every accepted request, load or store, produces
// exactly one rvalid pulse one cycle wide, in acceptance order. rdata and err
// are qualified by rvalid; rdata holds its last load value afterwards.
interface data_mem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  // Load/store unit side
  modport master (
    output req, we, addr, wmask, wdata,
    input  ready, rvalid, rdata, err
  );

  // Memory responder side
  modport slave (
    input  req, we, addr, wmask, wdata,
    output ready, rvalid, rdata, err
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: on-chip data RAM behind the core's data port.
// Word-aligned loads and byte-masked stores, with WAIT_STATES extra busy
// cycles per request so the core's stall path can be exercised.
//
// Optional feature macro: DMEM_ERR_EN
//   defined   -> accesses outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS)
//                complete with err=1, stores are dropped, loads return 0.
//   undefined -> err is tied low and out-of-range addresses alias into the
//                RAM through the modulo word index.
//
// Debug: dbg_state_o (0 = IDLE, 1 = BUSY) and dbg_count_o expose the FSM.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic       clk_i,
  input  logic       reset_i,
  data_mem_if.slave  bus,
  output logic       dbg_state_o,
  output logic [3:0] dbg_count_o
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_CNT  = 4'(WAIT_STATES);
  localparam bit          ZERO_WAIT = (WAIT_STATES == 0);
  localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  // Request captured at acceptance, used only when WAIT_STATES > 0
  logic        lat_we_q, lat_we_d;
  logic [31:0] lat_addr_q, lat_addr_d;
  logic [3:0]  lat_wmask_q, lat_wmask_d;
  logic [31:0] lat_wdata_q, lat_wdata_d;

  // Response registers
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Operation being completed this cycle
  logic        accept;
  logic        complete;
  logic        op_we;
  logic [31:0] op_addr;
  logic [3:0]  op_wmask;
  logic [31:0] op_wdata;
  logic [31:0] offset;
  logic [AW-1:0] idx;
  logic        in_range;
  logic        do_write;
  logic        do_read;
  logic        unused_offset;

  logic [31:0] mem_q [DEPTH_WORDS];

  // Ready only in IDLE; acceptance is the req & ready edge
  assign accept = (state_q == S_IDLE) & bus.req;

  // With zero wait states the request completes on its own accept edge using
  // the live bus fields; otherwise it completes on the counter's 1->0 edge
  // using the captured fields. Gating with reset_i keeps a held request from
  // touching the RAM while reset is asserted.
  assign complete = reset_i & (ZERO_WAIT ? accept
                                         : ((state_q == S_BUSY) && (cnt_q == 4'd1)));

  assign op_we    = ZERO_WAIT ? bus.we    : lat_we_q;
  assign op_addr  = ZERO_WAIT ? bus.addr  : lat_addr_q;
  assign op_wmask = ZERO_WAIT ? bus.wmask : lat_wmask_q;
  assign op_wdata = ZERO_WAIT ? bus.wdata : lat_wdata_q;

  // Word index: byte offset from BASE_ADDR, low two bits dropped, modulo depth
  assign offset        = op_addr - BASE_ADDR;
  assign idx           = offset[AW+1:2];
  assign unused_offset = ^offset;

`ifdef DMEM_ERR_EN
  // Below-base addresses wrap to huge offsets, so one unsigned compare covers both ends
  assign in_range = ({1'b0, offset} < SPAN);
`else
  assign in_range = 1'b1;
`endif

  assign do_write = complete & op_we & in_range;
  assign do_read  = complete & ~op_we;

  // FSM state, wait counter and captured request
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= 32'd0;
      lat_wmask_q <= 4'd0;
      lat_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      lat_wmask_q <= lat_wmask_d;
      lat_wdata_q <= lat_wdata_d;
    end
  end

  // Next state: IDLE -> BUSY on accept when wait states exist, back on count 1->0
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_wmask_d = lat_wmask_q;
    lat_wdata_d = lat_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept && !ZERO_WAIT) begin
          state_d     = S_BUSY;
          cnt_d       = WAIT_CNT;
          lat_we_d    = bus.we;
          lat_addr_d  = bus.addr;
          lat_wmask_d = bus.wmask;
          lat_wdata_d = bus.wdata;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // FSM outputs: handshake ready and debug view of the state
  always_comb begin
    bus.ready   = (state_q == S_IDLE);
    dbg_state_o = (state_q == S_BUSY);
    dbg_count_o = cnt_q;
  end

  // Response next-state: pulse rvalid after completion, update rdata on loads only
  always_comb begin
    rvalid_d = complete;
    rdata_d  = rdata_q;
    err_d    = 1'b0;
    if (do_read) begin
      rdata_d = in_range ? mem_q[idx] : 32'd0;
    end
`ifdef DMEM_ERR_EN
    err_d = complete & ~in_range;
`endif
  end

  // Response registers
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign bus.err    = err_q;

  // RAM byte-lane write on store completion; contents survive reset
  always_ff @(posedge clk_i) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (op_wmask[b]) begin
          mem_q[idx][8*b +: 8] <= op_wdata[8*b +: 8];
        end
      end
    end
  end

`ifndef SYNTHESIS
  // BUSY is only ever entered with a non-zero count
  a_busy_cnt: assert property (@(posedge clk_i) disable iff (!reset_i)
    (state_q == S_BUSY) |-> (cnt_q != 4'd0));
  // err is meaningful only alongside rvalid
  a_err_qual: assert property (@(posedge clk_i) disable iff (!reset_i)
    err_q |-> rvalid_q);
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (0, 2 and 3 wait states)
// share one driver; sel picks which instance sees req and whose outputs are
// observed. Expected {err, rdata} pairs are queued at acceptance and popped
// on each rvalid pulse.
module tb_data_mem_responder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  // ---------------- shared stimulus ----------------
  logic [1:0]  sel;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  wmask;
  logic [31:0] wdata;

  data_mem_if bus0 ();
  data_mem_if bus1 ();
  data_mem_if bus2 ();

  assign bus0.req = req & (sel == 2'd0);
  assign bus1.req = req & (sel == 2'd1);
  assign bus2.req = req & (sel == 2'd2);
  assign bus0.we = we;       assign bus1.we = we;       assign bus2.we = we;
  assign bus0.addr = addr;   assign bus1.addr = addr;   assign bus2.addr = addr;
  assign bus0.wmask = wmask; assign bus1.wmask = wmask; assign bus2.wmask = wmask;
  assign bus0.wdata = wdata; assign bus1.wdata = wdata; assign bus2.wdata = wdata;

  logic       st0, st1, st2;
  logic [3:0] cn0, cn1, cn2;

  data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(0)) u_dut0 (
    .clk_i(clk), .reset_i(reset_n), .bus(bus0), .dbg_state_o(st0), .dbg_count_o(cn0));
  data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(2)) u_dut1 (
    .clk_i(clk), .reset_i(reset_n), .bus(bus1), .dbg_state_o(st1), .dbg_count_o(cn1));
  data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(3)) u_dut2 (
    .clk_i(clk), .reset_i(reset_n), .bus(bus2), .dbg_state_o(st2), .dbg_count_o(cn2));

  // Observed outputs of the selected instance
  logic        ready_m, rvalid_m, err_m, state_m;
  logic [31:0] rdata_m;
  logic [3:0]  cnt_m;
  always_comb begin
    ready_m = bus0.ready; rvalid_m = bus0.rvalid; rdata_m = bus0.rdata;
    err_m = bus0.err; state_m = st0; cnt_m = cn0;
    if (sel == 2'd1) begin
      ready_m = bus1.ready; rvalid_m = bus1.rvalid; rdata_m = bus1.rdata;
      err_m = bus1.err; state_m = st1; cnt_m = cn1;
    end else if (sel == 2'd2) begin
      ready_m = bus2.ready; rvalid_m = bus2.rvalid; rdata_m = bus2.rdata;
      err_m = bus2.err; state_m = st2; cnt_m = cn2;
    end
  end

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp_v);
    end
  endtask

  // Pop one expectation per completion pulse
  always @(negedge clk) begin
    if (reset_n && rvalid_m) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got rvalid=1 on sel %0d, required no pending request", sel);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("resp_rdata", rdata_m, e[31:0]);
        chk("resp_err", {31'd0, err_m}, {31'd0, e[32]});
      end
    end
  end

  // ---------------- driver tasks (called #1 after a rising edge) ----------------
  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] m,
                       input logic [31:0] d, input logic e_err, input logic [31:0] e_rd);
    int n;
    n = 0;
    req = 1'b1; we = w; addr = a; wmask = m; wdata = d;
    while (!ready_m && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready_m) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: ready=%b after %0d cycles, required 1", ready_m, n);
      req = 1'b0;
    end else begin
      exp_q.push_back({e_err, e_rd});
      @(posedge clk); #1;
      req = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", exp_q.size(), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NVEC = 17;
  vec_t tbl[NVEC];

  initial begin
    // Back-to-back on the zero-wait instance; stores expect the held rdata
    tbl[0]  = '{1'b1, 32'h0000_1000, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    tbl[1]  = '{1'b0, 32'h0000_1000, 4'b0000, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b1, 32'h0000_1004, 4'b1111, 32'h1122_3344, 1'b0, 32'hDEAD_BEEF};
    tbl[3]  = '{1'b1, 32'h0000_1004, 4'b0010, 32'h0000_AB00, 1'b0, 32'hDEAD_BEEF};
    tbl[4]  = '{1'b0, 32'h0000_1004, 4'b0000, 32'h0000_0000, 1'b0, 32'h1122_AB44};
    tbl[5]  = '{1'b1, 32'h0000_1008, 4'b1111, 32'h5A5A_5A5A, 1'b0, 32'h1122_AB44};
    tbl[6]  = '{1'b0, 32'h0000_1008, 4'b0000, 32'h0000_0000, 1'b0, 32'h5A5A_5A5A};
    tbl[7]  = '{1'b1, 32'h0000_1008, 4'b1111, 32'h1234_5678, 1'b0, 32'h5A5A_5A5A};
    tbl[8]  = '{1'b1, 32'h0000_1008, 4'b0000, 32'hFFFF_FFFF, 1'b0, 32'h5A5A_5A5A};
    tbl[9]  = '{1'b0, 32'h0000_100B, 4'b0000, 32'h0000_0000, 1'b0, 32'h1234_5678};
    tbl[10] = '{1'b1, 32'h0000_1000, 4'b1001, 32'hAA00_00BB, 1'b0, 32'h1234_5678};
    tbl[11] = '{1'b0, 32'h0000_1001, 4'b0000, 32'h0000_0000, 1'b0, 32'hAAAD_BEBB};
`ifdef DMEM_ERR_EN
    tbl[12] = '{1'b0, 32'h0000_0FFC, 4'b0000, 32'h0000_0000, 1'b1, 32'h0000_0000};
    tbl[13] = '{1'b1, 32'h0000_2000, 4'b1111, 32'h0000_0077, 1'b1, 32'h0000_0000};
    tbl[14] = '{1'b0, 32'h0000_1000, 4'b0000, 32'h0000_0000, 1'b0, 32'hAAAD_BEBB};
    tbl[15] = '{1'b1, 32'h0000_1FFC, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'hAAAD_BEBB};
    tbl[16] = '{1'b0, 32'h0000_1FFC, 4'b0000, 32'h0000_0000, 1'b0, 32'hCAFE_F00D};
`else
    tbl[12] = '{1'b1, 32'h0000_2000, 4'b1111, 32'h0000_0077, 1'b0, 32'hAAAD_BEBB};
    tbl[13] = '{1'b0, 32'h0000_1000, 4'b0000, 32'h0000_0000, 1'b0, 32'h0000_0077};
    tbl[14] = '{1'b1, 32'h0000_0FFC, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0000_0077};
    tbl[15] = '{1'b0, 32'h0000_1FFC, 4'b0000, 32'h0000_0000, 1'b0, 32'hCAFE_F00D};
    tbl[16] = '{1'b0, 32'h0000_0FFC, 4'b0000, 32'h0000_0000, 1'b0, 32'hCAFE_F00D};
`endif
  end

  // ---------------- test sequence ----------------
  initial begin
    sel = 2'd0; req = 1'b0; we = 1'b0; addr = 32'd0; wmask = 4'd0; wdata = 32'd0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready0", {31'd0, bus0.ready}, 32'd1);
    chk("rst_ready1", {31'd0, bus1.ready}, 32'd1);
    chk("rst_ready2", {31'd0, bus2.ready}, 32'd1);
    chk("rst_rvalid", {29'd0, bus0.rvalid, bus1.rvalid, bus2.rvalid}, 32'd0);
    chk("rst_err", {29'd0, bus0.err, bus1.err, bus2.err}, 32'd0);
    chk("rst_rdata0", bus0.rdata, 32'd0);
    chk("rst_rdata1", bus1.rdata, 32'd0);
    chk("rst_fsm1", {27'd0, st1, cn1}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Table: zero wait states, one request per cycle, rvalid one cycle later
    sel = 2'd0;
    for (int i = 0; i < NVEC; i++) begin
      issue(tbl[i].we, tbl[i].addr, tbl[i].mask, tbl[i].wdata, tbl[i].exp_err, tbl[i].exp_rdata);
      chk("latency0_rvalid", {31'd0, rvalid_m}, 32'd1);
    end
    drain();

    // Two wait states: ready low for two cycles, held req ignored meanwhile
    sel = 2'd1;
    issue(1'b1, 32'h0000_1010, 4'b1111, 32'h0101_0101, 1'b0, 32'h0);
    issue(1'b1, 32'h0000_1014, 4'b1111, 32'h2468_ACE0, 1'b0, 32'h0);
    drain();
    req = 1'b1; we = 1'b0; addr = 32'h0000_1014; wmask = 4'b0000; wdata = 32'd0;
    chk("w2_c0_ready", {31'd0, ready_m}, 32'd1);
    exp_q.push_back({1'b0, 32'h2468_ACE0});
    @(posedge clk); #1;
    chk("w2_c1_ready", {31'd0, ready_m}, 32'd0);
    chk("w2_c1_rvalid", {31'd0, rvalid_m}, 32'd0);
    chk("w2_c1_cnt", {28'd0, cnt_m}, 32'd2);
    we = 1'b1; addr = 32'h0000_1010; wmask = 4'b1111; wdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    chk("w2_c2_ready", {31'd0, ready_m}, 32'd0);
    chk("w2_c2_rvalid", {31'd0, rvalid_m}, 32'd0);
    chk("w2_c2_cnt", {28'd0, cnt_m}, 32'd1);
    req = 1'b0;
    @(posedge clk); #1;
    chk("w2_c3_rvalid", {31'd0, rvalid_m}, 32'd1);
    chk("w2_c3_ready", {31'd0, ready_m}, 32'd1);
    drain();
    issue(1'b0, 32'h0000_1010, 4'b0000, 32'd0, 1'b0, 32'h0101_0101);
    drain();

    // Three wait states: reset while BUSY drops the latched store
    sel = 2'd2;
    issue(1'b1, 32'h0000_100C, 4'b1111, 32'h0000_0000, 1'b0, 32'h0);
    drain();
    issue(1'b1, 32'h0000_100C, 4'b1111, 32'hFFFF_FFFF, 1'b0, 32'h0);
    chk("w3_busy", {31'd0, state_m}, 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("w3_rst_ready", {31'd0, ready_m}, 32'd1);
    chk("w3_rst_rvalid", {31'd0, rvalid_m}, 32'd0);
    chk("w3_rst_fsm", {27'd0, state_m, cnt_m}, 32'd0);
    void'(exp_q.pop_back());
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    repeat (3) begin
      chk("w3_no_rvalid", {31'd0, rvalid_m}, 32'd0);
      @(posedge clk); #1;
    end
    issue(1'b0, 32'h0000_100C, 4'b0000, 32'd0, 1'b0, 32'h0000_0000);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
